// File: rtl/multicycle_arith_logic_unit_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states and
// the helper that splits single-cycle from iterative operations.
package alu_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULHU = 4'd11,
    ALU_DIV   = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_REM   = 4'd14,
    ALU_REMU  = 4'd15
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input alu_ctrl_e op);
    logic iter;
    case (op)
      ALU_MUL, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: iter = 1'b1;
      default:                                                 iter = 1'b0;
    endcase
    return iter;
  endfunction

  function automatic logic is_signed_div(input alu_ctrl_e op);
    logic sdiv;
    case (op)
      ALU_DIV, ALU_REM: sdiv = 1'b1;
      default:          sdiv = 1'b0;
    endcase
    return sdiv;
  endfunction

endpackage

// File: rtl/multicycle_arith_logic_unit_iter_muldiv.sv
// Iterative datapath: unsigned shift-add multiply and restoring divide sharing
// one 2*WIDTH accumulator, one bit per cycle, WIDTH iterations per operation.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  alu_ctrl_e        op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  alu_ctrl_e          op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step_s;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;

  logic               is_mul_s;
  logic [WIDTH:0]     sum_s, trial_s, diff_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_s, rem_s;

  assign is_mul_s = (op_q == ALU_MUL) || (op_q == ALU_MULHU);

  // One iteration of the shared datapath, selected by the latched operation
  always_comb begin
    sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s  = trial_s - {1'b0, opb_q};
    if (is_mul_s) begin
      acc_step_s = {sum_s, acc_q[WIDTH-1:1]};
    end else if (trial_s >= {1'b0, opb_q}) begin
      acc_step_s = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step_s = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result is taken from the last step so it can be registered by the top
  always_comb begin
    quo_s = acc_step_s[WIDTH-1:0];
    rem_s = acc_step_s[2*WIDTH-1:WIDTH];
    case (op_q)
      ALU_MUL:            result_o = acc_step_s[WIDTH-1:0];
      ALU_MULHU:          result_o = acc_step_s[2*WIDTH-1:WIDTH];
      ALU_DIV, ALU_DIVU:  result_o = (qneg_q && !div0_q) ? ({WIDTH{1'b0}} - quo_s) : quo_s;
      ALU_REM, ALU_REMU:  result_o = rneg_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;
      default:            result_o = {WIDTH{1'b0}};
    endcase
  end

  assign done_o = (cnt_q == CW'(1));

  // Operand load on start, otherwise iterate while the counter is non-zero
  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    mag_a_s = (is_signed_div(op_i) && a_i[WIDTH-1]) ? ({WIDTH{1'b0}} - a_i) : a_i;
    mag_b_s = (is_signed_div(op_i) && b_i[WIDTH-1]) ? ({WIDTH{1'b0}} - b_i) : b_i;
    if (start_i) begin
      cnt_d  = CW'(WIDTH);
      op_d   = op_i;
      div0_d = (b_i == {WIDTH{1'b0}});
      if ((op_i == ALU_MUL) || (op_i == ALU_MULHU)) begin
        acc_d  = {{WIDTH{1'b0}}, b_i};
        opb_d  = a_i;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, mag_a_s};
        opb_d  = mag_b_s;
        qneg_d = is_signed_div(op_i) && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        rneg_d = is_signed_div(op_i) && a_i[WIDTH-1];
      end
    end else if (cnt_q != {CW{1'b0}}) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = acc_step_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath state; reset discards any operation in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= {CW{1'b0}};
      op_q   <= ALU_ADD;
      acc_q  <= {(2*WIDTH){1'b0}};
      opb_q  <= {WIDTH{1'b0}};
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      div0_q <= div0_d;
    end
  end

endmodule

// File: rtl/multicycle_arith_logic_unit.sv
// Execute-stage ALU: single-cycle ops computed combinationally, mul/div handed
// to the iterative datapath; one op in flight, result held until drained.
module multicycle_arith_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       Control,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Out
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;

  alu_ctrl_e        ctrl_s;
  logic             accept_s;
  logic             start_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_result_s;

  assign ctrl_s   = alu_ctrl_e'(Control);
  assign shamt_s  = In2[SHW-1:0];
  assign accept_s = In_valid && In_ready;
  assign start_s  = accept_s && is_iterative(ctrl_s);

  // Accept in IDLE, or in DONE when the consumer drains in the same cycle
  always_comb begin
    if (state_q == IDLE) begin
      In_ready = 1'b1;
    end else if (state_q == DONE) begin
      In_ready = Out_ready;
    end else begin
      In_ready = 1'b0;
    end
  end

  // Single-cycle operations
  always_comb begin
    case (ctrl_s)
      ALU_ADD:  alu_res_s = In1 + In2;
      ALU_SUB:  alu_res_s = In1 - In2;
      ALU_XOR:  alu_res_s = In1 ^ In2;
      ALU_OR:   alu_res_s = In1 | In2;
      ALU_AND:  alu_res_s = In1 & In2;
      ALU_SLL:  alu_res_s = In1 << shamt_s;
      ALU_SRL:  alu_res_s = In1 >> shamt_s;
      ALU_SRA:  alu_res_s = WIDTH'($signed(In1) >>> shamt_s);
      ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
      ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (In1 < In2)};
      default:  alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk_i    (Clk),
    .rst_ni   (Rst_n),
    .start_i  (start_s),
    .op_i     (ctrl_s),
    .a_i      (In1),
    .b_i      (In2),
    .done_o   (md_done_s),
    .result_o (md_result_s)
  );

  // Control FSM with registered result and valid
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_s) begin
            if (is_iterative(ctrl_s)) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_q       <= alu_res_s;
            end
          end else if ((state_q == DONE) && Out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q     <= state_q;
          end
        end
        BUSY: begin
          if (md_done_s) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_q       <= md_result_s;
          end else begin
            state_q     <= BUSY;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Out_valid = out_valid_q;
  assign Out       = out_q;

endmodule

// File: tb/tb_multicycle_arith_logic_unit.sv
// Directed and random checks of multicycle_arith_logic_unit at WIDTH=32.
module tb_multicycle_arith_logic_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [3:0]  Control;
  logic        Out_valid;
  logic        Out_ready;
  logic [31:0] Out;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_arith_logic_unit #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In1       (In1),
    .In2       (In2),
    .Control   (Control),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out       (Out)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    logic [31:0] r;
    p   = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = {31'd0, ($signed(a) < $signed(b))};
      4'd9:  r = {31'd0, (a < b)};
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: r = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      4'd13: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd14: r = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op from IDLE, scramble inputs after accept, wait for result, drain it
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_rdy);
    Control = c; In1 = a; In2 = b; In_valid = 1'b1; Out_ready = 1'b0;
    tick();
    In_valid = 1'b0; Control = ~c; In1 = ~a; In2 = 32'h5A5A_0F0F;
    lat = 1; busy_rdy = 0;
    while (!Out_valid && lat < 100) begin
      if (In_ready) busy_rdy++;
      tick();
      lat++;
    end
    res = Out;
    Out_ready = 1'b1;
    tick();
    Out_ready = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat, busy_rdy;
    run_op(c, a, b, res, lat, busy_rdy);
    check_eq({tag, "_res"}, res, exp);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (exp_lat > 1) check_eq({tag, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] ea;
    int bad, vcount, issued, drained;
    logic acc_hs, out_hs;

    Rst_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b0;
    In1 = 32'd0; In2 = 32'd0; Control = 4'd0;
    repeat (3) tick();
    check_eq("rst_out_valid", {31'd0, Out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, In_ready}, 32'd1);
    check_eq("rst_out", Out, 32'd0);
    Rst_n = 1'b1;
    tick();

    vec("sub",     4'd1,  32'd5,          32'd7,          32'hFFFF_FFFE, 1);
    vec("sra",     4'd7,  32'h8000_0000,  32'd4,          32'hF800_0000, 1);
    vec("slt",     4'd8,  32'hFFFF_FFFF,  32'd1,          32'd1,         1);
    vec("sltu",    4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0,         1);
    vec("sll33",   4'd5,  32'd3,          32'd33,         32'd6,         1);
    vec("xor",     4'd2,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'hFF00_EDCB,  1);
    vec("mul",     4'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         33);
    vec("mulhu",   4'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
    vec("div",     4'd12, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33);
    vec("rem",     4'd14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33);
    vec("divu0",   4'd13, 32'd12345,      32'd0,          32'hFFFF_FFFF, 33);
    vec("remu0",   4'd15, 32'd9,          32'd0,          32'd9,         33);
    vec("div_ovf", 4'd12, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33);
    vec("rem_ovf", 4'd14, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         33);
    vec("divu",    4'd13, 32'd100,        32'd7,          32'd14,        33);

    // Reset in the middle of a DIVU
    Control = 4'd13; In1 = 32'd100; In2 = 32'd7; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    repeat (4) tick();
    Rst_n = 1'b0;
    tick();
    check_eq("midrst_out_valid", {31'd0, Out_valid}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, In_ready}, 32'd1);
    check_eq("midrst_out", Out, 32'd0);
    Rst_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      tick();
      if (Out_valid) vcount++;
    end
    check_eq("midrst_no_stale", 32'(vcount), 32'd0);
    vec("post_rst_add", 4'd0, 32'd2, 32'd2, 32'd4, 1);

    // Backpressure in DONE, then drain with back-to-back accept
    Control = 4'd0; In1 = 32'd10; In2 = 32'd20; In_valid = 1'b1; Out_ready = 1'b0;
    tick();
    In_valid = 1'b0;
    check_eq("bp_valid", {31'd0, Out_valid}, 32'd1);
    check_eq("bp_out", Out, 32'd30);
    bad = 0;
    repeat (10) begin
      tick();
      if (Out !== 32'd30 || In_ready !== 1'b0 || Out_valid !== 1'b1) bad++;
    end
    check_eq("bp_stable", 32'(bad), 32'd0);
    Control = 4'd0; In1 = 32'd1; In2 = 32'd2; In_valid = 1'b1; Out_ready = 1'b1;
    #1;
    check_eq("bp_b2b_ready", {31'd0, In_ready}, 32'd1);
    tick();
    In_valid = 1'b0; Out_ready = 1'b0;
    check_eq("bp_b2b_valid", {31'd0, Out_valid}, 32'd1);
    check_eq("bp_b2b_out", Out, 32'd3);
    Out_ready = 1'b1;
    tick();
    Out_ready = 1'b0;
    check_eq("bp_drained", {31'd0, Out_valid}, 32'd0);

    // Random traffic against the reference model
    issued = 0; drained = 0;
    for (int cyc = 0; cyc < 60000 && drained < 1000; cyc++) begin
      if (!In_valid && issued < 1000 && $urandom_range(0, 3) != 0) begin
        Control = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 5))
          0:       In1 = 32'h8000_0000;
          1:       In1 = 32'($urandom_range(0, 20));
          default: In1 = $urandom();
        endcase
        case ($urandom_range(0, 6))
          0:       In2 = 32'd0;
          1:       In2 = 32'hFFFF_FFFF;
          2:       In2 = 32'($urandom_range(1, 40));
          default: In2 = $urandom();
        endcase
        In_valid = 1'b1;
      end
      Out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc_hs = In_valid && In_ready;
      out_hs = Out_valid && Out_ready;
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          check_eq("rand_dup", 32'd1, 32'd0);
        end else begin
          ea = exp_q.pop_front();
          check_eq("rand_res", Out, ea);
        end
        drained++;
      end
      if (acc_hs) begin
        exp_q.push_back(ref_alu(Control, In1, In2));
        issued++;
      end
      tick();
      if (acc_hs) In_valid = 1'b0;
    end
    check_eq("rand_drained", 32'(drained), 32'd1000);
    check_eq("rand_leftover", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
